legv8_program_loader: RTL
=========================

# legv8_program_loader

Encoding front end for the LEGv8 5-stage core's instruction memory. The block accepts symbolic instruction requests: opcode enum, register numbers and a signed immediate. It range-checks each one, encodes it into the 32-bit machine word that the core's decode stage expects, and writes the words to consecutive instruction-memory addresses. It is used by benches and by the boot path to load programs before the core is released from reset.

## Interface
Parameters:
- `ADDR_W`, default 7: instruction-memory word-address width. Capacity is `2**ADDR_W` words.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request.
- `req_op` in 4: an `op_e` value: ADDI, ADDS, AND, B, B_LT, CBZ, EOR, LDUR, LSR, STUR, SUBS.
- `req_rd` in 5: Rd, or Rt for LDUR/STUR/CBZ.
- `req_rn` in 5: Rn.
- `req_rm` in 5: Rm.
- `req_imm` in 32: signed immediate, offset or shamt.
- `req_last` in 1: this request is the final word of the program.
- `restart` in 1: leave DONE/ERR, clear the address and count, return to IDLE.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out ADDR_W: word address.
- `imem_wdata` out 32: encoded instruction.
- `count` out ADDR_W+1: number of words written.
- `done` out 1: the program load completed.
- `err` out 1: an illegal request was rejected. Sticky.

## Operation
- FSM states: IDLE, WRITE, DONE, ERR.
- IDLE: `req_ready`=1. On `req_valid & req_ready`:
  - If the request is legal: latch the encoded word and go to WRITE.
  - If the request is illegal: go to ERR. Nothing is written.
- WRITE: `imem_we`=1 for exactly one cycle. At the end of the cycle, `imem_addr` and `count` increment.
  - Go to DONE if `req_last` was set, or if `count` reaches `2**ADDR_W` (memory full).
  - Otherwise return to IDLE.
- DONE: `done`=1 and `req_ready`=0. `restart` returns to IDLE with `imem_addr`=0 and `count`=0. `done` and `err` clear at the same time.
- ERR: `err`=1 and `req_ready`=0. `restart` behaves as in DONE.
- Encodings (bit fields):
  - R-type (ADDS 10101011000, AND 10001010000, EOR 11001010000, SUBS 11101011000): opcode[31:21], Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0].
  - LSR (11010011010): Rm field=0, shamt=imm[5:0].
  - ADDI (1001000100): opcode[31:22], imm12[21:10], Rn, Rd.
  - LDUR 11111000010 / STUR 11111000000: opcode[31:21], imm9[20:12], [11:10]=00, Rn, Rt.
  - B (000101): opcode[31:26], imm26[25:0].
  - CBZ (10110100): opcode[31:24], imm19[23:5], Rt[4:0].
  - B.LT (01010100): opcode[31:24], imm19[23:5], cond[4:0]=01011.
- Legality checks (any failure means illegal):
  - ADDI: 0..4095.
  - LDUR/STUR: -256..255.
  - LSR: 0..63.
  - CBZ/B.LT: -2^18..2^18-1.
  - B: -2^25..2^25-1.
  - `req_op` must be a defined enum value.
- Immediates are truncated two's-complement to the field width after the range check passes.
- A `restart` received in IDLE or WRITE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=0 in the first cycle after reset, then 1.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `count`=0, `done`=0, `err`=0.
- Latency: the handshake at edge E0 gives `imem_we`=1 with addr/data valid between E0 and E1. Memory samples the write at E1.
- Throughput: one word per 2 cycles. `req_ready` is 0 during WRITE.
- All outputs are registered. The block has no combinational path from inputs to outputs.
- `imem_wdata` holds its last value outside WRITE.
- Reset sampled at E1 while in WRITE: memory still samples the write at E1. State, address and count go to their reset values.
- Full boundary: the write at address `2**ADDR_W-1` sends the FSM to DONE even if `req_last`=0. `count` then equals `2**ADDR_W`.

## Structure
- `legv8_pkg` holds:
  - `op_e`.
  - The 11-, 10-, 8- and 6-bit opcode constants.
  - `COND_LT`=5'b01011.
  - Immediate range limits.
  - The FSM state enum.
- Sub-module `legv8_encode`: combinational `op_e` + fields → {word[31:0], legal}. The top-level holds only the FSM, address and count registers.

## Test plan
- ADDI rd=1, rn=0, imm=5 at address 0 → `imem_wdata`=0x91001401, `imem_we` for one cycle, `count`=1.
- ADDS rd=3, rn=1, rm=2 → 0xAB020023.
- LDUR rt=2, rn=1, imm=8 → 0xF8408022.
- Branches, issued back-to-back:
  - B imm=-1 → 0x17FFFFFF.
  - B.LT imm=2 → 0x5400004B.
  - CBZ rt=4, imm=-2 → 0xB4FFFFC4.
  - Addresses 0,1,2; `req_ready` low every other cycle.
- Illegal request: ADDI imm=4096 → `err`=1, no `imem_we`, `req_ready`=0. `restart` → IDLE with `count`=0 and `err`=0.
- Full memory: `ADDR_W`=2, four legal requests with `req_last`=0 → `done`=1 after the 4th write, `count`=4, a 5th `req_valid` is not accepted.
- Reset asserted while in WRITE → next cycle all outputs at reset values. Subsequent requests write from address 0.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 program loader:
// request opcodes, machine opcodes, immediate limits, FSM states.
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_ADDS = 4'd1,
    OP_AND  = 4'd2,
    OP_B    = 4'd3,
    OP_B_LT = 4'd4,
    OP_CBZ  = 4'd5,
    OP_EOR  = 4'd6,
    OP_LDUR = 4'd7,
    OP_LSR  = 4'd8,
    OP_STUR = 4'd9,
    OP_SUBS = 4'd10
  } op_e;

  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_BCND = 8'b01010100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam logic [4:0] COND_LT = 5'b01011;

  localparam int ADDI_MIN  = 0;
  localparam int ADDI_MAX  = 4095;
  localparam int DT_MIN    = -256;
  localparam int DT_MAX    = 255;
  localparam int SHAMT_MIN = 0;
  localparam int SHAMT_MAX = 63;
  localparam int CB_MIN    = -(1 << 18);
  localparam int CB_MAX    = (1 << 18) - 1;
  localparam int BR_MIN    = -(1 << 25);
  localparam int BR_MAX    = (1 << 25) - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  function automatic logic in_range(
    input logic signed [31:0] v,
    input int lo,
    input int hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/legv8_encode.sv
// Combinational encoder: symbolic request to 32-bit LEGv8 word
// plus a legality flag covering opcode and immediate range.
module legv8_encode
  import legv8_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic signed [31:0] simm;

  assign simm = $signed(imm);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_ADDS: word = {OPC_ADDS, rm, 6'd0, rn, rd};
      OP_AND:  word = {OPC_AND,  rm, 6'd0, rn, rd};
      OP_EOR:  word = {OPC_EOR,  rm, 6'd0, rn, rd};
      OP_SUBS: word = {OPC_SUBS, rm, 6'd0, rn, rd};
      OP_LSR: begin
        legal = in_range(simm, SHAMT_MIN, SHAMT_MAX);
        word  = {OPC_LSR, 5'd0, imm[5:0], rn, rd};
      end
      OP_ADDI: begin
        legal = in_range(simm, ADDI_MIN, ADDI_MAX);
        word  = {OPC_ADDI, imm[11:0], rn, rd};
      end
      OP_LDUR: begin
        legal = in_range(simm, DT_MIN, DT_MAX);
        word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
      end
      OP_STUR: begin
        legal = in_range(simm, DT_MIN, DT_MAX);
        word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
      end
      OP_B: begin
        legal = in_range(simm, BR_MIN, BR_MAX);
        word  = {OPC_B, imm[25:0]};
      end
      OP_CBZ: begin
        legal = in_range(simm, CB_MIN, CB_MAX);
        word  = {OPC_CBZ, imm[18:0], rd};
      end
      OP_B_LT: begin
        legal = in_range(simm, CB_MIN, CB_MAX);
        word  = {OPC_BCND, imm[18:0], COND_LT};
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/legv8_program_loader.sv
// Loads encoded LEGv8 instructions into consecutive imem words,
// one word per two cycles, stopping on last request, full or error.
module legv8_program_loader
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rn,
  input  logic [4:0]        req_rm,
  input  logic [31:0]       req_imm,
  input  logic              req_last,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  state_e      state;
  logic        last_q;
  logic [31:0] enc_word;
  logic        enc_legal;

  legv8_encode u_enc (
    .op    (req_op),
    .rd    (req_rd),
    .rn    (req_rn),
    .rm    (req_rm),
    .imm   (req_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (enc_legal) begin
              imem_wdata <= enc_word;
              imem_we    <= 1'b1;
              last_q     <= req_last;
              state      <= S_WRITE;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WRITE: begin
          imem_we   <= 1'b0;
          imem_addr <= imem_addr + ADDR_ONE;
          count     <= count + CNT_ONE;
          // Writing the top word means memory is now full.
          if (last_q || (&imem_addr)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_DONE, S_ERR: begin
          if (restart) begin
            imem_addr <= '0;
            count     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
